// File: rtl/jt900h_shctl_if.sv
// Bus bundle between the multi-bit shift sequencer and its requester / ALU.
// The slave side is the sequencer; the master side issues requests and hosts the ALU.
interface jt900h_shctl_if;
  logic        start;
  logic [2:0]  kind;
  logic [3:0]  cnt;
  logic        bs, ws;
  logic [31:0] din;
  logic        cin;
  logic [31:0] alu_rslt;
  logic        alu_c;
  logic [31:0] op2;
  logic [4:0]  alu_sel;
  logic [2:0]  cx_sel;
  logic        cfl, sbs, sws;
  logic        busy, done;
  logic [31:0] rslt;
  logic        cout;

  modport master (
    output start, kind, cnt, bs, ws, din, cin, alu_rslt, alu_c,
    input  op2, alu_sel, cx_sel, cfl, sbs, sws, busy, done, rslt, cout
  );

  modport slave (
    input  start, kind, cnt, bs, ws, din, cin, alu_rslt, alu_c,
    output op2, alu_sel, cx_sel, cfl, sbs, sws, busy, done, rslt, cout
  );
endinterface

// File: rtl/jt900h_shctl.sv
// Multi-bit shift/rotate sequencer: iterates the ALU's single-bit shift cnt' times.
// Optional macro JT900H_SHCTL_ABORT_EN adds an abort input that cancels a running shift.
module jt900h_shctl (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  jt900h_shctl_if.slave        bus
`ifdef JT900H_SHCTL_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // ALU operation codes; NOP_ALU passes op2 through untouched
  localparam logic [4:0] NOP_ALU = 5'd0;
  localparam logic [4:0] SHL_ALU = 5'd1;
  localparam logic [4:0] SHR_ALU = 5'd2;

  // Shifted-in bit source: 0, carry flag, operand MSB, operand LSB
  localparam logic [2:0] ZERO_CX = 3'd0;
  localparam logic [2:0] CIN_CX  = 3'd1;
  localparam logic [2:0] SA_CX   = 3'd2;
  localparam logic [2:0] SH_CX   = 3'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] rslt_q, rslt_d;
  logic        cfl_q, cfl_d;
  logic        cout_q, cout_d;
  logic        sbs_q, sbs_d;
  logic        sws_q, sws_d;
  logic [4:0]  rem_q, rem_d;
  logic        abort_w;

`ifdef JT900H_SHCTL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op2_d   = op2_q;
    rslt_d  = rslt_q;
    cfl_d   = cfl_q;
    cout_d  = cout_q;
    sbs_d   = sbs_q;
    sws_d   = sws_q;
    rem_d   = rem_q;
    if (cen) begin
      case (state_q)
        IDLE: if (bus.start) begin
          op2_d   = bus.din;
          cfl_d   = bus.cin;
          sbs_d   = bus.bs;
          sws_d   = bus.ws;
          rem_d   = (bus.cnt == 4'd0) ? 5'd16 : {1'b0, bus.cnt};
          state_d = SHIFT;
        end
        SHIFT: begin
          if (abort_w) begin
            state_d = IDLE;
          end else begin
            op2_d = bus.alu_rslt;
            cfl_d = bus.alu_c;
            rem_d = rem_q - 5'd1;
            if (rem_q == 5'd1) state_d = DONE;
          end
        end
        DONE: begin
          // Result is committed on leaving DONE so an abort here leaves rslt/cout intact
          state_d = IDLE;
          if (!abort_w) begin
            rslt_d = op2_q;
            cout_d = cfl_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op2_q   <= '0;
      rslt_q  <= '0;
      cfl_q   <= 1'b0;
      cout_q  <= 1'b0;
      sbs_q   <= 1'b0;
      sws_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op2_q   <= op2_d;
      rslt_q  <= rslt_d;
      cfl_q   <= cfl_d;
      cout_q  <= cout_d;
      sbs_q   <= sbs_d;
      sws_q   <= sws_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    bus.alu_sel = NOP_ALU;
    bus.cx_sel  = ZERO_CX;
    if (state_q == SHIFT) begin
      case (bus.kind)
        3'd0: begin bus.alu_sel = SHL_ALU; bus.cx_sel = SA_CX;   end // RLC
        3'd1: begin bus.alu_sel = SHR_ALU; bus.cx_sel = SH_CX;   end // RRC
        3'd2: begin bus.alu_sel = SHL_ALU; bus.cx_sel = CIN_CX;  end // RL
        3'd3: begin bus.alu_sel = SHR_ALU; bus.cx_sel = CIN_CX;  end // RR
        3'd4: begin bus.alu_sel = SHL_ALU; bus.cx_sel = ZERO_CX; end // SLA
        3'd5: begin bus.alu_sel = SHR_ALU; bus.cx_sel = SA_CX;   end // SRA
        3'd6: begin bus.alu_sel = SHL_ALU; bus.cx_sel = ZERO_CX; end // SLL
        default: begin bus.alu_sel = SHR_ALU; bus.cx_sel = ZERO_CX; end // SRL
      endcase
    end
  end

  assign bus.op2  = op2_q;
  assign bus.cfl  = cfl_q;
  assign bus.sbs  = sbs_q;
  assign bus.sws  = sws_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.rslt = bus.done ? op2_q : rslt_q;
  assign bus.cout = bus.done ? cfl_q : cout_q;

endmodule

// File: tb/tb_jt900h_shctl.sv
// Directed bench for jt900h_shctl; a behavioural single-bit shift ALU closes the loop.
// Abort checks are compiled in only when JT900H_SHCTL_ABORT_EN is defined.
module tb_jt900h_shctl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;
`ifdef JT900H_SHCTL_ABORT_EN
  logic abort = 1'b0;
`endif
  int n_chk = 0;
  int n_fail = 0;

  jt900h_shctl_if bus ();

  jt900h_shctl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .bus   (bus)
`ifdef JT900H_SHCTL_ABORT_EN
    ,
    .abort (abort)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU: 1=shift left, 2=shift right, else pass; cx 0=zero,1=cfl,2=msb,3=lsb
  logic [31:0] a_o, a_mask, a_sh;
  logic        a_ins;
  int          a_msb;
  always_comb begin
    a_o    = bus.op2;
    a_msb  = bus.sbs ? 7 : (bus.sws ? 15 : 31);
    a_mask = bus.sbs ? 32'h0000_00FF : (bus.sws ? 32'h0000_FFFF : 32'hFFFF_FFFF);
    case (bus.cx_sel)
      3'd1:    a_ins = bus.cfl;
      3'd2:    a_ins = a_o[a_msb];
      3'd3:    a_ins = a_o[0];
      default: a_ins = 1'b0;
    endcase
    a_sh = a_o;
    bus.alu_c = bus.cfl;
    if (bus.alu_sel == 5'd1) begin
      a_sh      = (a_o << 1) | {31'd0, a_ins};
      bus.alu_c = a_o[a_msb];
    end else if (bus.alu_sel == 5'd2) begin
      a_sh      = ((a_o & a_mask) >> 1) | ({31'd0, a_ins} << a_msb);
      bus.alu_c = a_o[0];
    end
    bus.alu_rslt = (a_o & ~a_mask) | (a_sh & a_mask);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and waits (bounded) for done; lat counts cen-qualified edges
  task automatic run_op(input logic [2:0] k, input logic [3:0] c, input logic b, input logic w,
                        input logic [31:0] d, input logic ci, input logic toggle, input logic mid_start,
                        output int lat, output logic [31:0] r, output logic co, output logic seen);
    logic ce;
    bus.kind = k; bus.cnt = c; bus.bs = b; bus.ws = w; bus.din = d; bus.cin = ci;
    bus.start = 1'b1; cen = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1; seen = 1'b0; r = '0; co = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        r = bus.rslt; co = bus.cout; seen = 1'b1;
        break;
      end
      if (toggle) cen = ~cen;
      bus.start = mid_start && (i == 1);
      if (mid_start && i == 1) bus.din = 32'h1234_5678;
      ce = cen;
      tick();
      if (ce) lat++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", bus.done); end
    n_chk++; if (bus.op2 !== 32'h0) begin n_fail++; $display("FAIL reset_op2 got %h want 0", bus.op2); end
    n_chk++; if ({bus.rslt, bus.cout, bus.cfl, bus.sbs, bus.sws} !== 36'h0)
      begin n_fail++; $display("FAIL reset_misc got %h/%b%b%b%b want 0", bus.rslt, bus.cout, bus.cfl, bus.sbs, bus.sws); end
    n_chk++; if (bus.alu_sel !== 5'd0) begin n_fail++; $display("FAIL reset_alu_sel got %0d want 0", bus.alu_sel); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sla_byte();
    int lat; logic [31:0] r; logic co, seen;
    run_op(3'd4, 4'd1, 1'b1, 1'b0, 32'h81, 1'b0, 1'b0, 1'b0, lat, r, co, seen);
    n_chk++; if (!seen || lat != 2) begin n_fail++; $display("FAIL sla_latency got %0d seen %0b want 2", lat, seen); end
    n_chk++; if (r[7:0] !== 8'h02) begin n_fail++; $display("FAIL sla_rslt got %h want 02", r[7:0]); end
    n_chk++; if (co !== 1'b1) begin n_fail++; $display("FAIL sla_cout got %0b want 1", co); end
    tick();
    n_chk++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL sla_done_pulse got done %0b busy %0b want 0 0", bus.done, bus.busy); end
    n_chk++; if (bus.rslt[7:0] !== 8'h02 || bus.cout !== 1'b1) begin n_fail++; $display("FAIL sla_hold got %h/%0b want 02/1", bus.rslt[7:0], bus.cout); end
  endtask

  task automatic test_rlc_word();
    int lat; logic [31:0] r; logic co, seen;
    run_op(3'd0, 4'd4, 1'b0, 1'b1, 32'h8001, 1'b0, 1'b0, 1'b0, lat, r, co, seen);
    n_chk++; if (!seen || lat != 5) begin n_fail++; $display("FAIL rlc_latency got %0d seen %0b want 5", lat, seen); end
    n_chk++; if (r[15:0] !== 16'h0018 || co !== 1'b0) begin n_fail++; $display("FAIL rlc_rslt got %h/%0b want 0018/0", r[15:0], co); end
    tick();
  endtask

  task automatic test_rr_byte_16();
    int lat; logic [31:0] r; logic co, seen;
    run_op(3'd3, 4'd0, 1'b1, 1'b0, 32'h01, 1'b0, 1'b0, 1'b0, lat, r, co, seen);
    n_chk++; if (!seen || lat != 17) begin n_fail++; $display("FAIL rr16_latency got %0d seen %0b want 17", lat, seen); end
    n_chk++; if (r[7:0] !== 8'h04 || co !== 1'b0) begin n_fail++; $display("FAIL rr16_rslt got %h/%0b want 04/0", r[7:0], co); end
    tick();
  endtask

  task automatic test_rl_carry();
    int lat; logic [31:0] r; logic co, seen;
    bus.kind = 3'd2; bus.cnt = 4'd1; bus.bs = 1'b1; bus.ws = 1'b0; bus.din = 32'h80; bus.cin = 1'b1;
    bus.start = 1'b1; cen = 1'b1;
    tick();
    bus.start = 1'b0;
    n_chk++; if (bus.cfl !== 1'b1 || bus.sbs !== 1'b1 || bus.sws !== 1'b0 || bus.op2 !== 32'h80)
      begin n_fail++; $display("FAIL rl_latch got cfl %0b sbs %0b sws %0b op2 %h want 1 1 0 80", bus.cfl, bus.sbs, bus.sws, bus.op2); end
    tick();
    n_chk++; if (bus.done !== 1'b1 || bus.rslt[7:0] !== 8'h01 || bus.cout !== 1'b1)
      begin n_fail++; $display("FAIL rl_rslt got done %0b %h/%0b want 1 01/1", bus.done, bus.rslt[7:0], bus.cout); end
    tick();
    lat = 0; r = '0; co = 1'b0; seen = 1'b0;
  endtask

  task automatic test_sra_long_mid_start();
    int lat; logic [31:0] r; logic co, seen;
    run_op(3'd5, 4'd3, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, lat, r, co, seen);
    n_chk++; if (!seen || lat != 4) begin n_fail++; $display("FAIL sra_latency got %0d seen %0b want 4", lat, seen); end
    n_chk++; if (r !== 32'hF000_0000 || co !== 1'b0) begin n_fail++; $display("FAIL sra_rslt got %h/%0b want f0000000/0", r, co); end
    tick();
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL sra_idle got busy %0b want 0", bus.busy); end
  endtask

  task automatic test_alu_sel();
    logic [4:0] esel [8];
    logic [2:0] ecx  [8];
    esel = '{5'd1, 5'd2, 5'd1, 5'd2, 5'd1, 5'd2, 5'd1, 5'd2};
    ecx  = '{3'd2, 3'd3, 3'd1, 3'd1, 3'd0, 3'd2, 3'd0, 3'd0};
    for (int k = 0; k < 8; k++) begin
      bus.kind = k[2:0]; bus.cnt = 4'd2; bus.bs = 1'b0; bus.ws = 1'b1; bus.din = 32'h1234; bus.cin = 1'b0;
      bus.start = 1'b1; cen = 1'b1;
      tick();
      bus.start = 1'b0;
      n_chk++; if (bus.alu_sel !== esel[k] || bus.cx_sel !== ecx[k])
        begin n_fail++; $display("FAIL alu_sel_kind%0d got %0d/%0d want %0d/%0d", k, bus.alu_sel, bus.cx_sel, esel[k], ecx[k]); end
      for (int i = 0; i < 10 && bus.busy; i++) tick();
    end
    n_chk++; if (bus.busy !== 1'b0 || bus.alu_sel !== 5'd0) begin n_fail++; $display("FAIL alu_sel_idle got busy %0b sel %0d want 0 0", bus.busy, bus.alu_sel); end
  endtask

  task automatic test_cen_toggle();
    int lat; logic [31:0] r; logic co, seen;
    run_op(3'd7, 4'd4, 1'b0, 1'b1, 32'h00F0, 1'b0, 1'b1, 1'b0, lat, r, co, seen);
    n_chk++; if (!seen || lat != 5) begin n_fail++; $display("FAIL srl_cen_latency got %0d seen %0b want 5", lat, seen); end
    n_chk++; if (r !== 32'h0000_000F || co !== 1'b0) begin n_fail++; $display("FAIL srl_cen_rslt got %h/%0b want 0000000f/0", r, co); end
    cen = 1'b0;
    tick(); tick();
    n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL cen_freeze_done got %0b want 1", bus.done); end
    cen = 1'b1;
    tick();
    n_chk++; if (bus.done !== 1'b0 || bus.rslt !== 32'h0000_000F) begin n_fail++; $display("FAIL cen_release got done %0b rslt %h want 0 0000000f", bus.done, bus.rslt); end
  endtask

  task automatic test_reset_mid();
    int saw;
    bus.kind = 3'd6; bus.cnt = 4'd8; bus.bs = 1'b0; bus.ws = 1'b1; bus.din = 32'h0003; bus.cin = 1'b1;
    bus.start = 1'b1; cen = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.op2 !== 32'h0 || bus.cfl !== 1'b0)
      begin n_fail++; $display("FAIL reset_mid got busy %0b done %0b op2 %h cfl %0b want 0 0 0 0", bus.busy, bus.done, bus.op2, bus.cfl); end
    #3 rst_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done || bus.busy) saw++;
    end
    n_chk++; if (saw != 0) begin n_fail++; $display("FAIL reset_mid_no_done got %0d active cycles want 0", saw); end
  endtask

`ifdef JT900H_SHCTL_ABORT_EN
  task automatic test_abort();
    int lat; logic [31:0] r; logic co, seen;
    run_op(3'd4, 4'd1, 1'b1, 1'b0, 32'h81, 1'b0, 1'b0, 1'b0, lat, r, co, seen);
    tick();
    bus.kind = 3'd6; bus.cnt = 4'd5; bus.ws = 1'b1; bus.bs = 1'b0; bus.din = 32'h1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_chk++; if (bus.busy !== 1'b0 || bus.rslt[7:0] !== 8'h02 || bus.cout !== 1'b1)
      begin n_fail++; $display("FAIL abort got busy %0b rslt %h cout %0b want 0 02 1", bus.busy, bus.rslt[7:0], bus.cout); end
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.kind = '0; bus.cnt = '0; bus.bs = 1'b0; bus.ws = 1'b0; bus.din = '0; bus.cin = 1'b0;
    test_reset();
    test_sla_byte();
    test_rlc_word();
    test_rr_byte_16();
    test_rl_carry();
    test_sra_long_mid_start();
    test_alu_sel();
    test_cen_toggle();
    test_reset_mid();
`ifdef JT900H_SHCTL_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jt900h_shctl.md
JT900H_SHCTL -- requirements
Module: jt900h_shctl

Interface
REQ-001 SHALL have port clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port cen  in  1  clock enable; state advances only when cen=1.
REQ-004 SHALL have port start  in  1  request a multi-bit shift; sampled only in IDLE with cen=1.
REQ-005 SHALL have port kind  in  3  0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SLL, 7 SRL.
REQ-006 SHALL have port cnt  in  4  shift count; 0 means 16.
REQ-007 SHALL have ports bs, ws  in  1 each  operand size byte or word; neither set means long.
REQ-008 SHALL have port din  in  32  operand to shift.
REQ-009 SHALL have port cin  in  1  carry flag at start.
REQ-010 SHALL have ports alu_rslt  in  32 and alu_c  in  1  ALU result and size-selected carry.
REQ-011 SHALL have port op2  out  32  working operand, driven to the ALU op2 input.
REQ-012 SHALL have ports alu_sel  out  5, cx_sel  out  3, cfl  out  1, sbs/sws  out  1 each  ALU controls, running carry to ALU cin, and latched size.
REQ-013 SHALL have ports busy  out  1, done  out  1, rslt  out  32, cout  out  1.

Function
REQ-014 SHALL implement states IDLE, SHIFT and DONE.
REQ-015 IDLE with start and cen SHALL latch op2=din, cfl=cin, sbs=bs, sws=ws, remaining=(cnt==0 ? 16 : cnt) and go to SHIFT.
REQ-016 SHIFT SHALL drive alu_sel/cx_sel as: RLC SHL_ALU/SA_CX; RRC SHR_ALU/SH_CX; RL SHL_ALU/CIN_CX; RR SHR_ALU/CIN_CX; SRA SHR_ALU/SA_CX; SLA and SLL SHL_ALU with a cx_sel code the ALU decodes as 0; SRL SHR_ALU with that same code.
REQ-017 Each SHIFT cycle with cen SHALL load op2=alu_rslt, cfl=alu_c and decrement remaining; if remaining was 1, SHALL go to DONE.
REQ-018 DONE SHALL assert done for exactly one cen cycle, hold rslt=op2 and cout=cfl, and then return to IDLE.
REQ-019 Latency SHALL be cnt' + 1 cen-qualified cycles from start to done, where cnt' is the effective count (1..16).
REQ-020 busy SHALL be 1 in SHIFT and DONE; start while busy SHALL be ignored.
REQ-021 cen=0 SHALL freeze all state, including done.
REQ-022 Outside SHIFT, alu_sel SHALL be a value the ALU treats as pass-through (no operation).
REQ-023 rslt and cout SHALL hold their values until the next DONE.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE and set busy=0, done=0, op2=0, rslt=0, cfl=0, cout=0, sbs=0, sws=0, remaining=0.
REQ-025 Reset mid-operation SHALL discard the operation, with no done pulse afterwards.

Configuration
REQ-026 With JT900H_SHCTL_ABORT_EN defined, the block SHALL add input abort (1 bit); abort=1 with cen in SHIFT or DONE SHALL return to IDLE next cycle without done and with rslt/cout unchanged.
REQ-027 Without JT900H_SHCTL_ABORT_EN, the abort port SHALL NOT exist and behaviour SHALL be as in REQ-014..REQ-025.

Verification
REQ-028 Byte SLA, din=0x81, cnt=1 -> done 2 cycles after start; rslt[7:0]=0x02, cout=1.
REQ-029 Word RLC, din=0x8001, cnt=4 -> rslt[15:0]=0x0018, cout=0, done on cycle 5.
REQ-030 Byte RR, din=0x01, cin=0, cnt=0 -> 16 iterations; rslt[7:0]=0x04, cout=0, done on cycle 17.
REQ-031 Long SRA, din=0x80000000, cnt=3 -> rslt=0xF0000000, cout=0; a start pulse mid-operation is ignored.
REQ-032 Toggle cen 50% during word SRL 0x00F0 cnt=4 -> rslt=0x000F, cout=0; rst_n pulse in SHIFT -> IDLE, busy=0, no done.
